cgra_tcdm_responder: RTL



---
 rtl/cgra_pkg.sv | 27 ++
 rtl/tcdm_bank.sv | 41 ++++
 rtl/cgra_tcdm_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_pkg
// Brief    : Shared CGRA constants, including the TCDM responder geometry.
// Revision : 1.0 - initial TCDM responder constants
// ============================================================================
package cgra_pkg;

    localparam int N_COL               = 4;
    localparam int DATA_BUS_ADD_WIDTH  = 32;
    localparam int DATA_BUS_DATA_WIDTH = 32;

    localparam int TCDM_RESP_N_BANKS    = 4;
    localparam int TCDM_RESP_BANK_WORDS = 1024;

    localparam int TCDM_BANK_OFFSET = 2;
    localparam int TCDM_ROW_OFFSET  = TCDM_BANK_OFFSET + $clog2(TCDM_RESP_N_BANKS);

    localparam logic [31:0] TCDM_OOR_RDATA = 32'hBADC_AB1E;

    // Row field starts right above the bank-select field for any bank count.
    function automatic int tcdm_row_offset(input int n_banks);
        return TCDM_BANK_OFFSET + ((n_banks > 1) ? $clog2(n_banks) : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank
// Brief    : Single-port synchronous SRAM bank with byte enables and
//            registered 1-cycle read data. Contents are not reset.
// Revision : 1.0 - initial version
// ============================================================================
module tcdm_bank #(
    parameter int WORDS      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [$clog2(WORDS)-1:0]  row_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_WIDTH/8; i++) begin
                    if (be_i[i]) begin
                        r_mem[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[row_i];
            end
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cgra_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : cgra_tcdm_responder
// Brief    : Multi-port TCDM responder: per-bank round-robin arbitration onto
//            word-interleaved SRAM banks, 1-cycle responses, OOR error flag.
// Revision : 1.0 - initial version
// ============================================================================
module cgra_tcdm_responder
    import cgra_pkg::*;
#(
    parameter int                    N_PORTS    = N_COL,
    parameter int                    N_BANKS    = TCDM_RESP_N_BANKS,
    parameter int                    BANK_WORDS = TCDM_RESP_BANK_WORDS,
    parameter int                    ADDR_WIDTH = DATA_BUS_ADD_WIDTH,
    parameter int                    DATA_WIDTH = DATA_BUS_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_PORTS-1:0]    tcdm_req_i,
    input  logic [ADDR_WIDTH-1:0] tcdm_add_i     [N_PORTS],
    input  logic [N_PORTS-1:0]    tcdm_wen_i,
    input  logic [3:0]            tcdm_be_i      [N_PORTS],
    input  logic [DATA_WIDTH-1:0] tcdm_wdata_i   [N_PORTS],
    output logic [N_PORTS-1:0]    tcdm_gnt_o,
    output logic [DATA_WIDTH-1:0] tcdm_rdata_o   [N_PORTS],
    output logic [N_PORTS-1:0]    tcdm_r_valid_o,
    output logic                  err_o
);

    localparam int c_BANK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int c_ROW_W   = $clog2(BANK_WORDS);
    localparam int c_PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int c_ROW_OFF = tcdm_row_offset(N_BANKS);

    // One extra bit so BASE + span cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] c_BASE = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] c_SPAN = (ADDR_WIDTH+1)'(N_BANKS * BANK_WORDS * 4);

    logic [c_BANK_W-1:0]   w_bank       [N_PORTS];
    logic [c_ROW_W-1:0]    w_row        [N_PORTS];
    logic [N_PORTS-1:0]    w_in_range;
    logic [N_PORTS-1:0]    w_bank_gnt   [N_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_rdata [N_BANKS];
    logic [N_PORTS-1:0]    w_gnt;
    logic [DATA_WIDTH-1:0] w_resp       [N_PORTS];

    logic [N_PORTS-1:0]    r_valid;
    logic [N_PORTS-1:0]    r_oor;
    logic [N_PORTS-1:0]    r_wen;
    logic [c_BANK_W-1:0]   r_bank       [N_PORTS];
    logic [DATA_WIDTH-1:0] r_hold       [N_PORTS];
    logic                  r_err;

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_bank[p]     = c_BANK_W'((tcdm_add_i[p] >> TCDM_BANK_OFFSET) & ADDR_WIDTH'(N_BANKS - 1));
            w_row[p]      = c_ROW_W'(tcdm_add_i[p] >> c_ROW_OFF);
            w_in_range[p] = ({1'b0, tcdm_add_i[p]} >= c_BASE) &&
                            ({1'b0, tcdm_add_i[p]} <  (c_BASE + c_SPAN));
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [N_PORTS-1:0] w_breq;
        logic [c_PTR_W-1:0] r_ptr;
        logic [c_PTR_W-1:0] w_idx;
        logic [c_PTR_W-1:0] w_win;
        logic               w_any;

        always_comb begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_breq[p] = tcdm_req_i[p] & w_in_range[p] & (w_bank[p] == c_BANK_W'(b));
            end
        end

        // Scan downward so the requester closest to the pointer wins last.
        always_comb begin
            w_any = 1'b0;
            w_win = '0;
            w_idx = '0;
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                w_idx = c_PTR_W'((int'(r_ptr) + i) % N_PORTS);
                if (w_breq[w_idx]) begin
                    w_any = 1'b1;
                    w_win = w_idx;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ptr <= '0;
            end else if (w_any) begin
                r_ptr <= (w_win == c_PTR_W'(N_PORTS - 1)) ? '0 : w_win + 1'b1;
            end
        end

        assign w_bank_gnt[b] = w_any ? (N_PORTS'(1) << w_win) : '0;

        tcdm_bank #(
            .WORDS      (BANK_WORDS),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk_i   (clk_i),
            .req_i   (w_any),
            .we_i    (tcdm_wen_i[w_win]),
            .be_i    (tcdm_be_i[w_win]),
            .row_i   (w_row[w_win]),
            .wdata_i (tcdm_wdata_i[w_win]),
            .rdata_o (w_bank_rdata[b])
        );
    end

    // Out-of-range requests bypass arbitration and are always granted.
    always_comb begin
        w_gnt = tcdm_req_i & ~w_in_range;
        for (int b = 0; b < N_BANKS; b++) begin
            w_gnt = w_gnt | w_bank_gnt[b];
        end
    end

    assign tcdm_gnt_o = w_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_oor   <= '0;
            r_wen   <= '0;
            r_err   <= 1'b0;
            for (int p = 0; p < N_PORTS; p++) begin
                r_bank[p] <= '0;
                r_hold[p] <= '0;
            end
        end else begin
            r_valid <= w_gnt;
            r_oor   <= ~w_in_range;
            r_wen   <= tcdm_wen_i;
            r_err   <= r_err | (|(w_gnt & ~w_in_range));
            for (int p = 0; p < N_PORTS; p++) begin
                r_bank[p] <= w_bank[p];
                if (r_valid[p]) begin
                    r_hold[p] <= w_resp[p];
                end
            end
        end
    end

    // Response data comes from the bank output register while valid, else holds.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (r_wen[p]) begin
                w_resp[p] = '0;
            end else if (r_oor[p]) begin
                w_resp[p] = DATA_WIDTH'(TCDM_OOR_RDATA);
            end else begin
                w_resp[p] = w_bank_rdata[r_bank[p]];
            end
            tcdm_rdata_o[p] = r_valid[p] ? w_resp[p] : r_hold[p];
        end
    end

    assign tcdm_r_valid_o = r_valid;
    assign err_o          = r_err;

endmodule
`default_nettype wire
